// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the ALU-based multiply sequencer: ALU opcodes, datapath width
// and FSM state encoding.
package alu_mul_sequencer_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mul_sequencer_alu_port_mux.sv
// 2:1 selector for the ALU input port: sequencer request when sel=1, EX-stage request
// otherwise.
module alu_port_mux #(
   parameter int unsigned XLEN = 32
) (
   input  logic            sel,
   input  logic [3:0]      ex_code,
   input  logic [XLEN-1:0] ex_a,
   input  logic [XLEN-1:0] ex_b,
   input  logic [3:0]      seq_code,
   input  logic [XLEN-1:0] seq_a,
   input  logic [XLEN-1:0] seq_b,
   output logic [3:0]      code,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b
);

   always_comb begin
      code = ex_code;
      a    = ex_a;
      b    = ex_b;
      if (sel) begin
         code = seq_code;
         a    = seq_a;
         b    = seq_b;
      end
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL (low XLEN bits) run on the shared single-cycle ALU.
// Build option MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned XLEN  = alu_mul_sequencer_pkg::XLEN,
   parameter int unsigned CNT_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   input  logic [3:0]      ex_alu_code,
   input  logic [XLEN-1:0] ex_alu_a,
   input  logic [XLEN-1:0] ex_alu_b,
   output logic [3:0]      alu_code,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_result
);

   state_e            state;
   logic [XLEN-1:0]   acc;
   logic [XLEN-1:0]   mcand;
   logic [XLEN-1:0]   mplier;
   logic [CNT_W-1:0]  cnt;
   logic              last_iter;
   logic [XLEN-1:0]   seq_b;

   always_comb begin
`ifdef MUL_EARLY_EXIT_EN
      last_iter = (cnt == CNT_W'(XLEN - 1)) || ((mplier >> 1) == '0);
`else
      last_iter = (cnt == CNT_W'(XLEN - 1));
`endif
      seq_b = mplier[0] ? mcand : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= op_a;
                  mplier <= op_b;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= alu_result;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (last_iter) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // acc already holds the final sum; publish it as we return to IDLE
               result <= acc;
               done   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   alu_port_mux #(
      .XLEN(XLEN)
   ) u_alu_port_mux (
      .sel      (state == RUN),
      .ex_code  (ex_alu_code),
      .ex_a     (ex_alu_a),
      .ex_b     (ex_alu_b),
      .seq_code (ALU_ADD),
      .seq_a    (acc),
      .seq_b    (seq_b),
      .code     (alu_code),
      .a        (alu_a),
      .b        (alu_b)
   );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: cycle-level model of busy/done/result/ALU ownership plus
// directed multiplies with hand-computed products and latencies.
module tb_alu_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [3:0]  ex_alu_code = 4'b0000;
   logic [31:0] ex_alu_a = '0;
   logic [31:0] ex_alu_b = '0;
   logic [3:0]  alu_code;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the real ALU: add on code 0, xor otherwise.
   always_comb alu_result = (alu_code == 4'b0000) ? alu_a + alu_b : alu_a ^ alu_b;

   alu_mul_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .ex_alu_code (ex_alu_code),
      .ex_alu_a    (ex_alu_a),
      .ex_alu_b    (ex_alu_b),
      .alu_code    (alu_code),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   function automatic int run_len(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
      for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
      return 1;
`else
      return (b === 32'hx) ? 32 : 32;
`endif
   endfunction

   // Model: an accepted multiply at cycle c is busy in c+1..c+L, done at c+L+1,
   // and its product is visible from c+L+2.
   bit          m_active = 0;
   int          m_cyc = 0;
   int          m_len = 0;
   logic [31:0] m_prod = '0;
   logic [31:0] m_res = '0;

   always @(negedge clk) begin
      logic busy_e, done_e;
      if (reset) begin
         m_active = 0;
         m_res    = '0;
      end else if (m_active && cyc == m_cyc + m_len + 2) begin
         m_res    = m_prod;
         m_active = 0;
      end
      busy_e = !reset && m_active && cyc > m_cyc && cyc <= m_cyc + m_len;
      done_e = !reset && m_active && cyc == m_cyc + m_len + 1;
      chk("m_busy", 32'(busy), 32'(busy_e));
      chk("m_done", 32'(done), 32'(done_e));
      chk("m_result", result, m_res);
      chk("m_alu_code", 32'(alu_code), busy_e ? 32'h0 : 32'(ex_alu_code));
      if (!busy_e) begin
         chk("m_alu_a", alu_a, ex_alu_a);
         chk("m_alu_b", alu_b, ex_alu_b);
      end
      if (!reset && !m_active && start) begin
         m_active = 1;
         m_cyc    = cyc;
         m_len    = run_len(op_b);
         m_prod   = op_a * op_b;
      end
   end

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int c);
      @(posedge clk);
      #1;
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      c     = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int i = 0; i < 100 && dc < 0; i++) begin
         @(negedge clk);
         if (done) dc = cyc;
      end
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
      int c, dc;
      start_op(a, b, c);
      wait_done(dc);
      chk("lat", 32'(dc - c), 32'(exp_lat));
      @(negedge clk);
      chk("res", result, exp_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, dc, n;
      ex_alu_code = 4'b0011;
      ex_alu_a    = 32'hF0;
      ex_alu_b    = 32'h3C;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_result", result, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_code", 32'(alu_code), 32'h3);
      chk("idle_a", alu_a, 32'hF0);
      chk("idle_b", alu_b, 32'h3C);

      // 3*5 with ALU ownership during RUN
      start_op(32'd3, 32'd5, c);
      ex_alu_code = 4'b0101;
      @(negedge clk);
      chk("run_code", 32'(alu_code), 32'h0);
      chk("run_busy", 32'(busy), 32'h1);
      wait_done(dc);
`ifdef MUL_EARLY_EXIT_EN
      chk("lat_3x5", 32'(dc - c), 32'd4);
`else
      chk("lat_3x5", 32'(dc - c), 32'd33);
`endif
      chk("done_code", 32'(alu_code), 32'h5);
      @(negedge clk);
      chk("res_3x5", result, 32'd15);
      chk("idle_code2", 32'(alu_code), 32'h5);

      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
`ifdef MUL_EARLY_EXIT_EN
      run_mul(32'h8000_0000, 32'd2, 32'h0, 3);
      run_mul(32'd123, 32'd0, 32'h0, 2);
`else
      run_mul(32'h8000_0000, 32'd2, 32'h0, 33);
      run_mul(32'd123, 32'd0, 32'h0, 33);
`endif

      // Second start during RUN must be ignored
      start_op(32'd9, 32'h8000_0001, c);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      op_a  = 32'd2;
      op_b  = 32'd2;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (cyc < c + 45) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("one_done", 32'(n), 32'd1);
      chk("res_ignore", result, 32'h8000_0009);

      // Asynchronous reset mid-RUN
      start_op(32'd5, 32'h8000_0003, c);
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      chk("arst_result", result, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
`ifdef MUL_EARLY_EXIT_EN
      run_mul(32'd7, 32'd6, 32'd42, 4);
`else
      run_mul(32'd7, 32'd6, 32'd42, 33);
`endif
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
